// File: rtl/skid_buf_pkg.sv
// skid_buf_pkg: shared state type and default widths for the skid buffer
package skid_buf_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/skid_buf_sat_cnt.sv
// sat_cnt: saturating up-counter that holds at all-ones until reset
module sat_cnt
    import skid_buf_pkg::*;
#(
    parameter int CNT_W = skid_buf_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count up on enable, stopping once every bit is set
    always_comb begin
        cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/skid_buf.sv
// skid_buf: two-entry skid buffer with registered ready; optional stall counter via SKID_BUF_STALL_CNT_EN
module skid_buf
    import skid_buf_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int CNT_W = skid_buf_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_q,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e       state_q, state_d;
    logic [N-1:0] main_q, main_d;
    logic [N-1:0] skid_q, skid_d;
    logic         in_xfer, out_xfer;

    // Handshake flags decode straight from the state register, so in_ready never sees out_ready
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_q     = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Next state and register loads; the skid slot only fills when the consumer stalls
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = in_d;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_d;
                end else if (in_xfer) begin
                    state_d = TWO;
                    skid_d  = in_d;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers; reset discards any held words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_BUF_STALL_CNT_EN
    sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (out_valid && !out_ready),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_skid_buf.sv
// tb_skid_buf: directed self-checking bench for skid_buf (stall counter built with CNT_W = 3)
module tb_skid_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_d;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_q;
    logic [2:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SKID_BUF_STALL_CNT_EN
    localparam int STALL5 = 5;
    localparam int STALL7 = 7;
`else
    localparam int STALL5 = 0;
    localparam int STALL7 = 0;
`endif

    skid_buf #(.N(8), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'h12;
        out_ready = 1'b1;
        #3;
        chk("rst_async_ovalid", 32'(out_valid), 0);
        chk("rst_async_iready", 32'(in_ready), 1);
        chk("rst_async_outq", 32'(out_q), 0);
        chk("rst_async_stall", 32'(stall_cnt), 0);
        step();
        step();
        chk("rst_held_ovalid", 32'(out_valid), 0);
        chk("rst_held_outq", 32'(out_q), 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post_rst_ovalid", 32'(out_valid), 0);

        in_valid = 1'b1;
        in_d     = 8'hA2;
        step();
        chk("single_ovalid", 32'(out_valid), 1);
        chk("single_outq", 32'(out_q), 'hA2);
        in_valid = 1'b0;
        step();
        chk("single_empty", 32'(out_valid), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'h11;
        step();
        chk("bp_one_iready", 32'(in_ready), 1);
        in_d = 8'h22;
        step();
        chk("bp_two_iready", 32'(in_ready), 0);
        chk("bp_two_outq", 32'(out_q), 'h11);
        in_d = 8'h33;
        step();
        chk("bp_ignore_outq", 32'(out_q), 'h11);
        chk("bp_ignore_iready", 32'(in_ready), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain_outq", 32'(out_q), 'h22);
        chk("bp_drain_ovalid", 32'(out_valid), 1);
        step();
        chk("bp_drain_empty", 32'(out_valid), 0);

        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_d     = 8'(i);
            step();
            chk($sformatf("stream_outq_%0d", i), 32'(out_q), i);
            chk($sformatf("stream_hs_%0d", i), 32'({out_valid, in_ready}), 'b11);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", 32'(out_valid), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'h55;
        step();
        in_d = 8'h66;
        step();
        chk("midrst_two", 32'(in_ready), 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ovalid", 32'(out_valid), 0);
        chk("midrst_iready", 32'(in_ready), 1);
        chk("midrst_outq", 32'(out_q), 0);
        chk("midrst_stall", 32'(stall_cnt), 0);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("midrst_lost", 32'(out_valid), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'h77;
        step();
        in_valid = 1'b0;
        chk("stall_start", 32'(stall_cnt), 0);
        repeat (5) step();
        chk("stall_five", 32'(stall_cnt), STALL5);
        repeat (5) step();
        chk("stall_sat", 32'(stall_cnt), STALL7);
        chk("stall_outq_stable", 32'(out_q), 'h77);
        out_ready = 1'b1;
        step();
        chk("stall_drain", 32'(out_valid), 0);
        step();
        chk("stall_hold", 32'(stall_cnt), STALL7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/skid_buf.md
SKID_BUF -- requirements
Module: skid_buf

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall counter width in bits.
REQ-003 clk  input  1  rising-edge clock; this is the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets the block.
REQ-005 in_valid  input  1  upstream asserts that in_d holds a word.
REQ-006 in_ready  output  1  block can accept a word; registered, with no combinational path from out_ready.
REQ-007 in_d  input  N  upstream data word.
REQ-008 out_valid  output  1  out_q holds a word for the downstream stage.
REQ-009 out_ready  input  1  downstream accepts out_q this cycle.
REQ-010 out_q  output  N  registered data word to the downstream register stage.
REQ-011 stall_cnt  output  CNT_W  count of stalled output cycles (see Configuration).

Function
REQ-012 A transfer SHALL occur on a rising edge when valid and ready are both 1 on the same port.
REQ-013 The FSM SHALL have three states: EMPTY (no word held), ONE (main register holds a word), TWO (main and skid registers both hold a word).
REQ-014 Outputs SHALL be: out_valid = 1 in ONE or TWO; in_ready = 1 in EMPTY or ONE.
REQ-015 EMPTY -> ONE SHALL occur on an input transfer; in_d is loaded into the main register, giving 1-cycle latency from in_d to out_q.
REQ-016 In ONE: input only -> TWO, with in_d loaded into the skid register.
REQ-017 In ONE: output only -> EMPTY.
REQ-018 In ONE: simultaneous input and output transfers -> stay in ONE, with in_d loaded into the main register.
REQ-019 In ONE: no transfer -> stay in ONE, with registers held.
REQ-020 In TWO: an output transfer -> ONE, with the skid word moved to the main register; in TWO no input transfer is possible because in_ready = 0.
REQ-021 Words SHALL leave in arrival order, with none dropped or duplicated.
REQ-022 out_q SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-023 in_d SHALL be ignored when in_ready = 0 or in_valid = 0.
REQ-024 Sustained in_valid = out_ready = 1 SHALL give one word per cycle throughput.

Reset
REQ-025 While reset = 0, asynchronously: state = EMPTY, out_valid = 0, in_ready = 1, out_q = 0, skid register = 0, stall_cnt = 0.
REQ-026 A reset asserted mid-operation SHALL discard every held word with no output transfer on that edge.
REQ-027 After reset deasserts, the first transfer SHALL occur no earlier than the first rising edge at which reset = 1.

Configuration
REQ-028 With macro SKID_BUF_STALL_CNT_EN defined, stall_cnt SHALL increment on every edge where out_valid = 1 and out_ready = 0.
REQ-029 With SKID_BUF_STALL_CNT_EN defined, stall_cnt SHALL saturate at 2^CNT_W-1 and clear only on reset.
REQ-030 Without SKID_BUF_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic SHALL be generated; all other behaviour is identical.

Structure
REQ-031 Package skid_buf_pkg SHALL hold the state enum type (EMPTY, ONE, TWO) and default constants DATA_W = 8 and CNT_W = 16.
REQ-032 The saturating stall counter SHALL be a sub-module named sat_cnt, parameterized by CNT_W, with an increment enable input.
REQ-033 sat_cnt SHALL be instantiated only when SKID_BUF_STALL_CNT_EN is defined.

Verification
REQ-034 Reset: hold reset = 0 with in_valid = 1 and in_d = 8'h12 -> out_valid = 0, in_ready = 1, out_q = 0, stall_cnt = 0.
REQ-035 Single word: in_d = 8'hA2 for one transfer with out_ready = 1 -> out_q = 8'hA2 and out_valid = 1 on the next cycle, then EMPTY.
REQ-036 Backpressure: out_ready = 0, send 8'h11 then 8'h22 -> in_ready = 0 after the second word; raise out_ready -> out_q = 8'h11 then 8'h22, in order.
REQ-037 Streaming: 12 consecutive words 0..11 with out_ready = 1 -> 12 output transfers on consecutive cycles, in order.
REQ-038 Stall count (macro defined): 5 cycles of out_valid = 1, out_ready = 0 -> stall_cnt = 5.
REQ-039 Stall count saturation: CNT_W = 3 with 10 stalled cycles -> stall_cnt = 7; macro undefined -> stall_cnt = 0.
REQ-040 Mid-operation reset: pulse reset = 0 while in TWO -> state EMPTY, out_valid = 0 immediately, and both held words are lost.
